digest_pager: RTL and testbench

DIGEST_PAGER -- requirements
Module: digest_pager

---
 rtl/pager_pkg.sv | 15 +
 rtl/btn_conditioner.sv | 55 +++++
 rtl/digest_pager.sv | 116 +++++++++++
 tb/tb_digest_pager.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pager_pkg.sv
// Shared types and defaults for the digest pager: state encoding, default
// geometry/dwell constants and the debounce counter width.
package pager_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam int DEF_DIGEST_W  = 512;
    localparam int DEF_WIN_W     = 16;
    localparam int DEF_DWELL_CYC = 1000;
    localparam int DEB_CNT_W     = 16;

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: two-flop synchroniser, optional debounce
// (PAGER_DEBOUNCE_EN), and a single-cycle rising-edge pulse.
module btn_conditioner
    import pager_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic r_s1;
    logic r_s2;
    logic r_prev;
    logic w_level;

`ifdef PAGER_DEBOUNCE_EN
    logic                 r_stable;
    logic [DEB_CNT_W-1:0] r_cnt;

    // Accept a new level only after it has differed from the accepted one for 2^16 cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_s2 == r_stable) begin
            r_cnt <= '0;
        end else if (&r_cnt) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_level = r_stable;
`else
    assign w_level = r_s2;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= btn;
            r_s2   <= r_s1;
            r_prev <= w_level;
        end
    end

    assign pulse = w_level & ~r_prev;

endmodule

// File: rtl/digest_pager.sv
// Digest pager: latches a hash result and pages through it one WIN_W-bit
// window at a time via buttons or auto-scroll. Optional macro: PAGER_DEBOUNCE_EN.
module digest_pager
    import pager_pkg::*;
#(
    parameter int DIGEST_W  = DEF_DIGEST_W,
    parameter int WIN_W     = DEF_WIN_W,
    parameter int DWELL_CYC = DEF_DWELL_CYC
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                digest_valid,
    input  logic [DIGEST_W-1:0]                 digest,
    output logic                                digest_ready,
    input  logic                                step_btn,
    input  logic                                back_btn,
    input  logic                                auto_en,
    output logic [WIN_W-1:0]                    window,
    output logic [$clog2(DIGEST_W/WIN_W)-1:0]   index,
    output logic                                loaded,
    output logic                                wrap_pulse,
    output logic                                dbg_state
);

    localparam int N_WIN = DIGEST_W / WIN_W;
    localparam int IDX_W = $clog2(N_WIN);
    localparam int DW_W  = $clog2(DWELL_CYC);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_WIN - 1);
    localparam logic [DW_W-1:0]  DW_MAX  = DW_W'(DWELL_CYC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DIGEST_W-1:0] r_digest;
    logic [WIN_W-1:0]    r_window;
    logic [IDX_W-1:0]    r_index;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [DW_W-1:0]     r_dwell;
    logic [DW_W-1:0]     w_dwell_nxt;
    logic                r_wrap;
    logic                w_wrap_nxt;
    logic                r_ready;
    logic                w_step_p;
    logic                w_back_p;
    logic                w_hs;
    logic                w_manual;
    logic                w_auto_tick;
    logic                w_fwd;
    logic                w_rev;

    btn_conditioner u_step (.clk(clk), .rst(rst), .btn(step_btn), .pulse(w_step_p));
    btn_conditioner u_back (.clk(clk), .rst(rst), .btn(back_btn), .pulse(w_back_p));

    assign w_hs        = digest_valid & r_ready;
    assign w_manual    = w_step_p | w_back_p;
    // Manual events own the cycle; auto advance only fires when no button event is present.
    assign w_auto_tick = (r_state == SHOW) & auto_en & (r_dwell == DW_MAX) & ~w_manual;
    assign w_fwd       = (w_step_p | w_auto_tick) & ~w_back_p;
    assign w_rev       = w_back_p & ~w_step_p;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_index;
        w_wrap_nxt  = 1'b0;
        w_dwell_nxt = r_dwell;
        if (w_hs) begin
            w_state_nxt = SHOW;
            w_idx_nxt   = '0;
            w_dwell_nxt = '0;
        end else if (r_state == SHOW) begin
            if (w_fwd) begin
                w_idx_nxt  = (r_index == IDX_MAX) ? '0 : r_index + 1'b1;
                w_wrap_nxt = (r_index == IDX_MAX);
            end else if (w_rev) begin
                w_idx_nxt  = (r_index == '0) ? IDX_MAX : r_index - 1'b1;
                w_wrap_nxt = (r_index == '0);
            end
            if (w_manual || !auto_en || w_auto_tick)
                w_dwell_nxt = '0;
            else
                w_dwell_nxt = r_dwell + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= EMPTY;
            r_digest <= '0;
            r_window <= '0;
            r_index  <= '0;
            r_dwell  <= '0;
            r_wrap   <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_idx_nxt;
            r_dwell <= w_dwell_nxt;
            r_wrap  <= w_wrap_nxt;
            r_ready <= 1'b1;
            // Window is refreshed from the next index so it tracks index on the same edge.
            if (w_hs) begin
                r_digest <= digest;
                r_window <= digest[WIN_W-1:0];
            end else if (r_state == SHOW) begin
                r_window <= r_digest[w_idx_nxt*WIN_W +: WIN_W];
            end
        end
    end

    assign digest_ready = r_ready;
    assign window       = r_window;
    assign index        = r_index;
    assign loaded       = (r_state == SHOW);
    assign wrap_pulse   = r_wrap;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_digest_pager.sv
// Directed bench for digest_pager with DWELL_CYC=8; digest word i = 16'hA000+i.
// Inputs are driven and outputs sampled on the falling edge.
module tb_digest_pager;

    localparam int DIGEST_W  = 512;
    localparam int WIN_W     = 16;
    localparam int DWELL_CYC = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                digest_valid;
    logic [DIGEST_W-1:0] digest;
    logic                digest_ready;
    logic                step_btn;
    logic                back_btn;
    logic                auto_en;
    logic [WIN_W-1:0]    window;
    logic [4:0]          index;
    logic                loaded;
    logic                wrap_pulse;
    logic                dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [DIGEST_W-1:0] pattern;

    always #5 clk = ~clk;

    digest_pager #(
        .DIGEST_W (DIGEST_W),
        .WIN_W    (WIN_W),
        .DWELL_CYC(DWELL_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digest_valid(digest_valid),
        .digest      (digest),
        .digest_ready(digest_ready),
        .step_btn    (step_btn),
        .back_btn    (back_btn),
        .auto_en     (auto_en),
        .window      (window),
        .index       (index),
        .loaded      (loaded),
        .wrap_pulse  (wrap_pulse),
        .dbg_state   (dbg_state)
    );

    // Press for 3 cycles (sync + edge latency), sample, release and let the synchroniser drain.
    task automatic press(input logic s, input logic b, output logic w_on, output logic w_after);
        step_btn = s;
        back_btn = b;
        repeat (3) @(negedge clk);
        w_on     = wrap_pulse;
        step_btn = 1'b0;
        back_btn = 1'b0;
        @(negedge clk);
        w_after  = wrap_pulse;
        repeat (2) @(negedge clk);
    endtask

    task automatic handshake(input string tag);
        digest       = pattern;
        digest_valid = 1'b1;
        @(negedge clk);
        digest_valid = 1'b0;
        n_cmp++;
        if (loaded !== 1'b1 || index !== 5'd0 || window !== 16'hA000 || digest_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s: loaded=%b index=%0d window=%h ready=%b, required 1/0/a000/1",
                     tag, loaded, index, window, digest_ready);
        end
    endtask

    task automatic test_reset();
        logic w1, w2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (index !== 5'd0 || window !== 16'h0 || loaded !== 1'b0 || wrap_pulse !== 1'b0 || digest_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: index=%0d window=%h loaded=%b wrap=%b ready=%b, required all 0",
                     index, window, loaded, wrap_pulse, digest_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (digest_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_release: got %b required 1", digest_ready);
        end
        press(1'b1, 1'b0, w1, w2);
        auto_en = 1'b1;
        repeat (10) @(negedge clk);
        auto_en = 1'b0;
        n_cmp++;
        if (index !== 5'd0 || window !== 16'h0 || loaded !== 1'b0 || w1 !== 1'b0) begin
            n_err++;
            $display("FAIL empty_ignores: index=%0d window=%h loaded=%b wrap=%b, required 0/0/0/0",
                     index, window, loaded, w1);
        end
    endtask

    task automatic test_step_back();
        logic w1, w2;
        handshake("handshake_first");
        repeat (3) press(1'b1, 1'b0, w1, w2);
        n_cmp++;
        if (index !== 5'd3 || window !== 16'hA003) begin
            n_err++;
            $display("FAIL three_steps: index=%0d window=%h required 3/a003", index, window);
        end
        press(1'b0, 1'b1, w1, w2);
        n_cmp++;
        if (index !== 5'd2 || window !== 16'hA002 || w1 !== 1'b0) begin
            n_err++;
            $display("FAIL one_back: index=%0d window=%h wrap=%b required 2/a002/0", index, window, w1);
        end
    endtask

    task automatic test_wrap();
        logic w1, w2;
        repeat (2) press(1'b0, 1'b1, w1, w2);
        press(1'b0, 1'b1, w1, w2);
        n_cmp++;
        if (index !== 5'd31 || window !== 16'hA01F || w1 !== 1'b1 || w2 !== 1'b0) begin
            n_err++;
            $display("FAIL back_wrap: index=%0d window=%h wrap=%b then %b required 31/a01f/1/0",
                     index, window, w1, w2);
        end
        press(1'b1, 1'b0, w1, w2);
        n_cmp++;
        if (index !== 5'd0 || window !== 16'hA000 || w1 !== 1'b1 || w2 !== 1'b0) begin
            n_err++;
            $display("FAIL step_wrap: index=%0d window=%h wrap=%b then %b required 0/a000/1/0",
                     index, window, w1, w2);
        end
    endtask

    task automatic test_cancel_and_hold();
        logic w1, w2;
        repeat (5) press(1'b1, 1'b0, w1, w2);
        press(1'b1, 1'b1, w1, w2);
        n_cmp++;
        if (index !== 5'd5 || window !== 16'hA005 || w1 !== 1'b0) begin
            n_err++;
            $display("FAIL cancel: index=%0d window=%h wrap=%b required 5/a005/0", index, window, w1);
        end
        step_btn = 1'b1;
        repeat (12) @(negedge clk);
        step_btn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (index !== 5'd6 || window !== 16'hA006) begin
            n_err++;
            $display("FAIL hold_one_event: index=%0d window=%h required 6/a006", index, window);
        end
    endtask

    task automatic test_auto();
        handshake("handshake_reload");
        auto_en = 1'b1;
        repeat (24) @(negedge clk);
        n_cmp++;
        if (index !== 5'd3 || window !== 16'hA003) begin
            n_err++;
            $display("FAIL auto_24: index=%0d window=%h required 3/a003", index, window);
        end
        repeat (4) @(negedge clk);
        handshake("handshake_mid_dwell");
        repeat (7) @(negedge clk);
        n_cmp++;
        if (index !== 5'd0) begin
            n_err++;
            $display("FAIL dwell_restart_hold: index=%0d required 0", index);
        end
        @(negedge clk);
        auto_en = 1'b0;
        n_cmp++;
        if (index !== 5'd1 || window !== 16'hA001) begin
            n_err++;
            $display("FAIL dwell_restart_adv: index=%0d window=%h required 1/a001", index, window);
        end
    endtask

    task automatic test_reset_mid();
        logic w1, w2;
        repeat (6) press(1'b1, 1'b0, w1, w2);
        n_cmp++;
        if (index !== 5'd7 || window !== 16'hA007) begin
            n_err++;
            $display("FAIL pre_reset: index=%0d window=%h required 7/a007", index, window);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_cmp++;
        if (index !== 5'd0 || window !== 16'h0 || loaded !== 1'b0 || digest_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: index=%0d window=%h loaded=%b ready=%b required 0/0/0/0",
                     index, window, loaded, digest_ready);
        end
        @(negedge clk);
        repeat (2) press(1'b1, 1'b0, w1, w2);
        n_cmp++;
        if (index !== 5'd0 || window !== 16'h0 || loaded !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_ignore: index=%0d window=%h loaded=%b required 0/0/0",
                     index, window, loaded);
        end
        handshake("handshake_after_reset");
        press(1'b1, 1'b0, w1, w2);
        n_cmp++;
        if (index !== 5'd1 || window !== 16'hA001) begin
            n_err++;
            $display("FAIL step_after_reload: index=%0d window=%h required 1/a001", index, window);
        end
    endtask

    initial begin
        for (int i = 0; i < DIGEST_W / WIN_W; i++)
            pattern[i*WIN_W +: WIN_W] = 16'hA000 + 16'(i);
        rst          = 1'b0;
        digest_valid = 1'b0;
        digest       = '0;
        step_btn     = 1'b0;
        back_btn     = 1'b0;
        auto_en      = 1'b0;
        @(negedge clk);
        test_reset();
        test_step_back();
        test_wrap();
        test_cancel_and_hold();
        test_auto();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
